instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  out  1  instruction fetch request.
REQ-005 SHALL have port imem_addr  out  32  fetch address, equal to pc.
REQ-006 SHALL have port imem_ready  in  1  fetch data valid this cycle.
REQ-007 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-008 SHALL have port ir  out  32  instruction register, drives the decoder's instruction input.
REQ-009 SHALL have ports ub, cb, memr, memw, regw  in  1 each  decoder control bits for ir.
REQ-010 SHALL have port imm  in  32  decoder sign-extended immediate (word offset for branches).
REQ-011 SHALL have port zero  in  1  register-zero flag for CBZ, valid in EXEC.
REQ-012 SHALL have ports dmem_req, dmem_we  out  1 each  data-memory request and write enable.
REQ-013 SHALL have port dmem_ready  in  1  data-memory access complete.
REQ-014 SHALL have port rf_we  out  1  gated register-file write enable.
REQ-015 SHALL have port link_data  out  32  instr_pc+4, write data for BL.
REQ-016 SHALL have ports pc, instr_pc  out  32 each  next-fetch PC and address of instruction in ir.
REQ-017 SHALL have port state  out  3  current FSM state, for debug.
REQ-018 SHALL have port retire  out  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-019 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; other encodings SHALL go to FETCH next cycle.
REQ-020 FETCH: imem_req=1 while in FETCH; on imem_ready, ir<=imem_rdata, instr_pc<=pc, go to DECODE; otherwise stay, unbounded wait.
REQ-021 imem_ready and dmem_ready SHALL be ignored outside FETCH and MEM respectively.
REQ-022 DECODE: exactly one cycle, no outputs asserted, go to EXEC.
REQ-023 EXEC, ub=1: pc<=instr_pc+(imm<<2); go to WB if regw, else FETCH.
REQ-024 EXEC, cb=1: pc<=instr_pc+(imm<<2) if zero=1, else instr_pc+4; go to FETCH.
REQ-025 EXEC, memr or memw: pc<=instr_pc+4; go to MEM.
REQ-026 EXEC, otherwise: pc<=instr_pc+4; go to WB if regw, else FETCH.
REQ-027 Priority in EXEC SHALL be ub > cb > memr/memw > default.
REQ-028 MEM: dmem_req=1, dmem_we=memw (memw wins if both memr and memw); on dmem_ready go to WB if memr, else FETCH.
REQ-029 WB: rf_we=1 for exactly one cycle; go to FETCH.
REQ-030 rf_we SHALL be asserted only in WB; dmem_we only in MEM.
REQ-031 retire SHALL pulse on the transition cycle into FETCH from EXEC, MEM or WB.
REQ-032 PC arithmetic SHALL be 32-bit modulo 2^32; imm<<2 drops the top bits; negative imm wraps correctly.
REQ-033 link_data SHALL be combinational instr_pc+4, modulo 2^32.

Reset
REQ-034 On reset: state=FETCH, pc=RESET_PC, instr_pc=0, ir=0.
REQ-035 On reset, imem_req, dmem_req, dmem_we, rf_we and retire SHALL be 0 in the following cycle.
REQ-036 Reset in any state, including mid-MEM, SHALL abandon the instruction with no rf_we and no retire.
REQ-037 reset SHALL take priority over every concurrent event.

Structure
REQ-038 The state encoding and the RESET_PC default SHALL reside in a shared package, seq_pkg.
REQ-039 Branch/sequential address computation SHALL be a sub-module pc_next(instr_pc, imm, take) -> target.

Verification
REQ-040 ADD X9,X20,X21 (0x8B150289), regw=1, imem_ready same cycle -> FETCH,DECODE,EXEC,WB; rf_we in cycle 4; pc=4; retire=1.
REQ-041 LDUR X9,[X10,#0], memr=1 regw=1, dmem_ready after 3 MEM cycles -> dmem_req 3 cycles, dmem_we=0, then WB rf_we=1; pc=instr_pc+4.
REQ-042 CBZ X7 imm=65 at instr_pc=0x100 -> zero=1: pc=0x204; zero=0: pc=0x104; rf_we never asserted.
REQ-043 BL imm=-5 at instr_pc=0x40, ub=1 regw=1 -> pc=0x2C; WB with link_data=0x44; rf_we=1.
REQ-044 imem_ready held low 5 cycles -> state stays FETCH, imem_req=1 and imem_addr stable throughout.
REQ-045 reset asserted during MEM of STUR -> next cycle state=FETCH, pc=RESET_PC, dmem_req=0, no retire.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and reset PC.
package seq_pkg;

   // FSM encoding is visible on the debug state port, so the values are fixed.
   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4
   } seq_state_e;

   localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: branch target (instr_pc + imm*4) or sequential (instr_pc + 4).
module pc_next (
   input  logic [31:0] instr_pc,
   input  logic [31:0] imm,
   input  logic        take,
   output logic [31:0] target
);

   // imm is a word offset; the shift drops the top two bits, and the add wraps mod 2^32.
   always_comb begin
      target = instr_pc + (take ? (imm << 2) : 32'd4);
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
module instr_sequencer
   import seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ResetPcDefault
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   input  logic        ub,
   input  logic        cb,
   input  logic        memr,
   input  logic        memw,
   input  logic        regw,
   input  logic [31:0] imm,
   input  logic        zero,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        rf_we,
   output logic [31:0] link_data,
   output logic [31:0] pc,
   output logic [31:0] instr_pc,
   output logic [2:0]  state,
   output logic        retire
);

   seq_state_e  state_q, state_d;
   logic [31:0] pc_q, instr_pc_q, ir_q;
   logic [31:0] target;
   logic        take;

   // Only an unconditional branch or a taken CBZ leaves the sequential path.
   always_comb begin
      take = ub | (cb & zero);
   end

   pc_next u_pc_next (
      .instr_pc (instr_pc_q),
      .imm      (imm),
      .take     (take),
      .target   (target)
   );

   // Next-state decode; EXEC priority is ub > cb > memory > default.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = imem_ready ? StDecode : StFetch;
         StDecode: state_d = StExec;
         StExec: begin
            if (ub) begin
               state_d = regw ? StWb : StFetch;
            end else if (cb) begin
               state_d = StFetch;
            end else if (memr || memw) begin
               state_d = StMem;
            end else begin
               state_d = regw ? StWb : StFetch;
            end
         end
         StMem: begin
            if (dmem_ready) begin
               state_d = memr ? StWb : StFetch;
            end else begin
               state_d = StMem;
            end
         end
         StWb:     state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   // State, PC and instruction registers; reset overrides every other event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StFetch;
         pc_q       <= RESET_PC;
         instr_pc_q <= 32'd0;
         ir_q       <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == StFetch && imem_ready) begin
            ir_q       <= imem_rdata;
            instr_pc_q <= pc_q;
         end
         if (state_q == StExec) begin
            pc_q <= target;
         end
      end
   end

   // Strobes decode from the state register; gating with reset abandons the instruction.
   always_comb begin
      imem_req  = (state_q == StFetch) && !reset;
      dmem_req  = (state_q == StMem) && !reset;
      dmem_we   = (state_q == StMem) && memw && !reset;
      rf_we     = (state_q == StWb) && !reset;
      retire    = ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) &&
                  (state_d == StFetch) && !reset;
      imem_addr = pc_q;
      pc        = pc_q;
      instr_pc  = instr_pc_q;
      ir        = ir_q;
      state     = state_q;
      link_data = instr_pc_q + 32'd4;
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: each task walks one instruction and checks per cycle.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] ir;
   logic        ub = 1'b0, cb = 1'b0, memr = 1'b0, memw = 1'b0, regw = 1'b0;
   logic [31:0] imm = 32'd0;
   logic        zero = 1'b0;
   logic        dmem_req, dmem_we;
   logic        dmem_ready = 1'b0;
   logic        rf_we;
   logic [31:0] link_data, pc, instr_pc;
   logic [2:0]  state;
   logic        retire;

   int total = 0;
   int bad = 0;

   instr_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ir(ir), .ub(ub), .cb(cb),
      .memr(memr), .memw(memw), .regw(regw), .imm(imm), .zero(zero),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .rf_we(rf_we),
      .link_data(link_data), .pc(pc), .instr_pc(instr_pc), .state(state), .retire(retire)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word in FETCH for one cycle and clear the decoder bits.
   task automatic fetch(input logic [31:0] word);
      imem_rdata = word;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      {ub, cb, memr, memw, regw, zero} = 6'b0;
      imm = 32'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
      total++; if ({dmem_req, dmem_we, rf_we, retire} !== 4'b0) begin bad++; $display("FAIL rst_strobes got=%b exp=0000", {dmem_req, dmem_we, rf_we, retire}); end
      total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
      total++; if ({ir, instr_pc} !== 64'h0) begin bad++; $display("FAIL rst_ir_ipc got=%h/%h exp=0/0", ir, instr_pc); end
      reset = 1'b0;
      #1;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_release_imem_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_add();
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL add_imem_addr got=%h exp=0", imem_addr); end
      fetch(32'h8B150289);
      regw = 1'b1;
      total++; if (state !== 3'd1) begin bad++; $display("FAIL add_decode_state got=%0d exp=1", state); end
      total++; if (ir !== 32'h8B150289) begin bad++; $display("FAIL add_ir got=%h exp=8b150289", ir); end
      total++; if ({imem_req, dmem_req, rf_we, retire} !== 4'b0) begin bad++; $display("FAIL add_decode_outs got=%b exp=0000", {imem_req, dmem_req, rf_we, retire}); end
      tick();
      total++; if ({state, retire, rf_we} !== {3'd2, 2'b00}) begin bad++; $display("FAIL add_exec got=%0d/%b/%b exp=2/0/0", state, retire, rf_we); end
      tick();
      total++; if ({state, rf_we, retire} !== {3'd4, 2'b11}) begin bad++; $display("FAIL add_wb got=%0d/%b/%b exp=4/1/1", state, rf_we, retire); end
      total++; if (pc !== 32'h4) begin bad++; $display("FAIL add_pc got=%h exp=4", pc); end
      regw = 1'b0;
      tick();
      total++; if ({state, rf_we, retire} !== {3'd0, 2'b00}) begin bad++; $display("FAIL add_back_fetch got=%0d/%b/%b exp=0/0/0", state, rf_we, retire); end
   endtask

   task automatic test_fetch_stall();
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if ({state, imem_req, imem_addr} !== {3'd0, 1'b1, 32'h4}) begin bad++; $display("FAIL stall_c%0d got=%0d/%b/%h exp=0/1/4", i, state, imem_req, imem_addr); end
      end
   endtask

   task automatic test_load();
      fetch(32'hF8400149);
      memr = 1'b1;
      regw = 1'b1;
      total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL ld_instr_pc got=%h exp=4", instr_pc); end
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         dmem_ready = (i == 2);
         #1;
         total++; if ({state, dmem_req, dmem_we, rf_we, retire} !== {3'd3, 4'b1000}) begin bad++; $display("FAIL ld_mem_c%0d got=%0d/%b%b%b%b exp=3/1000", i, state, dmem_req, dmem_we, rf_we, retire); end
         tick();
      end
      dmem_ready = 1'b0;
      total++; if ({state, rf_we, retire, dmem_req} !== {3'd4, 3'b110}) begin bad++; $display("FAIL ld_wb got=%0d/%b%b%b exp=4/110", state, rf_we, retire, dmem_req); end
      total++; if (pc !== 32'h8) begin bad++; $display("FAIL ld_pc got=%h exp=8", pc); end
      tick();
   endtask

   // Unconditional branch without link from the current FETCH address.
   task automatic branch(input logic [31:0] off, input logic [31:0] exp_pc, input string nm);
      fetch(32'h14000000);
      ub = 1'b1;
      imm = off;
      tick();
      total++; if ({retire, rf_we} !== 2'b10) begin bad++; $display("FAIL %s_exec_retire got=%b%b exp=10", nm, retire, rf_we); end
      tick();
      total++; if ({state, pc} !== {3'd0, exp_pc}) begin bad++; $display("FAIL %s_pc got=%0d/%h exp=0/%h", nm, state, pc, exp_pc); end
   endtask

   task automatic cbz(input logic z, input logic [31:0] exp_pc, input string nm);
      fetch(32'hB4000827);
      cb = 1'b1;
      imm = 32'd65;
      zero = z;
      total++; if (instr_pc !== 32'h100) begin bad++; $display("FAIL %s_instr_pc got=%h exp=100", nm, instr_pc); end
      tick();
      total++; if ({rf_we, retire} !== 2'b01) begin bad++; $display("FAIL %s_exec got=%b%b exp=01", nm, rf_we, retire); end
      tick();
      total++; if ({state, pc, rf_we} !== {3'd0, exp_pc, 1'b0}) begin bad++; $display("FAIL %s_pc got=%0d/%h/%b exp=0/%h/0", nm, state, pc, rf_we, exp_pc); end
   endtask

   task automatic test_cbz();
      branch(32'd62, 32'h100, "b_fwd");
      cbz(1'b1, 32'h204, "cbz_taken");
      branch(-32'sd65, 32'h100, "b_back");
      cbz(1'b0, 32'h104, "cbz_fall");
   endtask

   task automatic test_bl();
      branch(-32'sd49, 32'h40, "b_to40");
      fetch(32'h97FFFFFB);
      ub = 1'b1;
      regw = 1'b1;
      imm = -32'sd5;
      tick();
      total++; if ({link_data, retire} !== {32'h44, 1'b0}) begin bad++; $display("FAIL bl_exec got=%h/%b exp=44/0", link_data, retire); end
      tick();
      total++; if ({state, rf_we, retire} !== {3'd4, 2'b11}) begin bad++; $display("FAIL bl_wb got=%0d/%b%b exp=4/11", state, rf_we, retire); end
      total++; if ({pc, link_data} !== {32'h2C, 32'h44}) begin bad++; $display("FAIL bl_pc_link got=%h/%h exp=2c/44", pc, link_data); end
      tick();
   endtask

   task automatic test_mem_reset();
      fetch(32'hF8000149);
      memw = 1'b1;
      tick();
      tick();
      total++; if ({state, dmem_req, dmem_we} !== {3'd3, 2'b11}) begin bad++; $display("FAIL st_mem got=%0d/%b%b exp=3/11", state, dmem_req, dmem_we); end
      reset = 1'b1;
      dmem_ready = 1'b1;
      #1;
      total++; if ({retire, rf_we} !== 2'b00) begin bad++; $display("FAIL st_rst_retire got=%b%b exp=00", retire, rf_we); end
      tick();
      total++; if ({state, pc, dmem_req, retire, rf_we} !== {3'd0, 32'h0, 3'b000}) begin bad++; $display("FAIL st_rst_after got=%0d/%h/%b%b%b exp=0/0/000", state, pc, dmem_req, retire, rf_we); end
      reset = 1'b0;
      dmem_ready = 1'b0;
      memw = 1'b0;
      #1;
   endtask

   // PC arithmetic wraps: 0 + (-1<<2) and then 0xFFFFFFFC + 4.
   task automatic test_wrap();
      branch(-32'sd1, 32'hFFFF_FFFC, "wrap_neg");
      fetch(32'hD503201F);
      total++; if ({instr_pc, link_data} !== {32'hFFFF_FFFC, 32'h0}) begin bad++; $display("FAIL wrap_link got=%h/%h exp=fffffffc/0", instr_pc, link_data); end
      tick();
      total++; if (retire !== 1'b1) begin bad++; $display("FAIL wrap_nop_retire got=%b exp=1", retire); end
      tick();
      total++; if ({state, pc} !== {3'd0, 32'h0}) begin bad++; $display("FAIL wrap_pc got=%0d/%h exp=0/0", state, pc); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_fetch_stall();
      test_load();
      test_cbz();
      test_bl();
      test_mem_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
